// File: rtl/rf_dump_reader.sv
// rtl/rf_dump_reader.sv - register-file debug dump engine with valid/ready output
//
// Walks the register addresses START_ADDR..END_ADDR (inclusive, upward, wrapping
// modulo 2**AWL) through one asynchronous register-file read port. Each word is
// streamed out over a valid/ready handshake. HALT_REQ freezes the pipeline and
// suppresses register-file writes for the whole dump.
//
// Ports:
//   CLK, RST           clock; asynchronous active-high reset
//   START, ABORT       begin a dump (IDLE only); cancel an active dump (READ/SEND)
//   START_ADDR         first register, sampled on an accepted START
//   END_ADDR           last register (inclusive), sampled on an accepted START
//   RA / RD            register-file read address / combinational read data
//   DVALID/DREADY      output word handshake
//   DOUT / DADDR       captured register value and its address
//   BUSY               dump in progress (READ, SEND, FINISH)
//   HALT_REQ           registered pipeline freeze request
//   DONE               one-cycle pulse on normal completion
module rf_dump_reader #(
  parameter int AWL = 5,
  parameter int DWL = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic           ABORT,
  input  logic [AWL-1:0] START_ADDR,
  input  logic [AWL-1:0] END_ADDR,
  output logic [AWL-1:0] RA,
  input  logic [DWL-1:0] RD,
  output logic           DVALID,
  input  logic           DREADY,
  output logic [DWL-1:0] DOUT,
  output logic [AWL-1:0] DADDR,
  output logic           BUSY,
  output logic           HALT_REQ,
  output logic           DONE
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]     state;
  logic [AWL-1:0] cur;
  logic [AWL-1:0] last;

  // The read address is the walk pointer itself: it is loaded on START and
  // advanced on each handshake, so it is already stable for the READ cycle.
  assign RA   = cur;
  assign BUSY = (state != S_IDLE);
  assign DONE = (state == S_FINISH);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cur      <= '0;
      last     <= '0;
      DOUT     <= '0;
      DADDR    <= '0;
      DVALID   <= 1'b0;
      HALT_REQ <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // START wins over a simultaneous ABORT here; ABORT is meaningless in IDLE.
          if (START) begin
            cur      <= START_ADDR;
            last     <= END_ADDR;
            HALT_REQ <= 1'b1;
            state    <= S_READ;
          end
        end
        S_READ: begin
          if (ABORT) begin
            HALT_REQ <= 1'b0;
            state    <= S_IDLE;
          end else begin
            DOUT   <= RD;
            DADDR  <= cur;
            DVALID <= 1'b1;
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          // ABORT takes priority over a handshake in the same cycle; the word is dropped.
          if (ABORT) begin
            DVALID   <= 1'b0;
            HALT_REQ <= 1'b0;
            state    <= S_IDLE;
          end else if (DREADY) begin
            DVALID <= 1'b0;
            if (cur == last) begin
              state <= S_FINISH;
            end else begin
              cur   <= cur + 1'b1;
              state <= S_READ;
            end
          end
        end
        default: begin
          // FINISH: DONE is decoded from the state; HALT_REQ covers this cycle too.
          HALT_REQ <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb/tb_rf_dump_reader.sv - directed self-checking bench for rf_dump_reader
module tb_rf_dump_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        ABORT;
  logic [4:0]  START_ADDR;
  logic [4:0]  END_ADDR;
  logic [4:0]  RA;
  logic [31:0] RD;
  logic        DVALID;
  logic        DREADY;
  logic [31:0] DOUT;
  logic [4:0]  DADDR;
  logic        BUSY;
  logic        HALT_REQ;
  logic        DONE;

  rf_dump_reader #(.AWL(5), .DWL(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .START_ADDR(START_ADDR), .END_ADDR(END_ADDR),
    .RA(RA), .RD(RD), .DVALID(DVALID), .DREADY(DREADY),
    .DOUT(DOUT), .DADDR(DADDR), .BUSY(BUSY), .HALT_REQ(HALT_REQ), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Register-file model: async read, negedge write gated by HALT_REQ.
  logic [31:0] rf [32];
  logic        rfwe = 1'b0;
  logic [4:0]  rfwa = 5'd0;
  logic [31:0] rfwd = 32'd0;
  assign RD = rf[RA];
  always @(negedge CLK) if (rfwe && !HALT_REQ) rf[rfwa] = rfwd;

  // Beat / DONE monitor.
  logic [4:0]  bq_addr [$];
  logic [31:0] bq_data [$];
  int          bq_cyc  [$];
  int          cyc = 0;
  int          done_cnt = 0;
  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (!RST && DVALID && DREADY && !ABORT) begin
      bq_addr.push_back(DADDR);
      bq_data.push_back(DOUT);
      bq_cyc.push_back(cyc);
    end
    if (!RST && DONE) done_cnt = done_cnt + 1;
  end

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_q();
    bq_addr.delete();
    bq_data.delete();
    bq_cyc.delete();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!DVALID && n < 50) begin tick(); n++; end
    chk({"tmo_valid_", tag}, {31'd0, DVALID}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY && n < 200) begin tick(); n++; end
    chk({"tmo_idle_", tag}, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic start_dump(input logic [4:0] s, input logic [4:0] e);
    START_ADDR = s; END_ADDR = e; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    int bad;
    int d0;
    logic [31:0] hold_d;
    logic [4:0]  hold_a;
    logic [4:0]  exp_a [4];

    RST = 1'b1; START = 1'b0; ABORT = 1'b0; DREADY = 1'b0;
    START_ADDR = 5'd0; END_ADDR = 5'd0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    #2;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_halt", {31'd0, HALT_REQ}, 32'd0);
    chk("rst_dvalid", {31'd0, DVALID}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_ra", {27'd0, RA}, 32'd0);
    chk("rst_dout", DOUT, 32'd0);
    tick(); tick();
    RST = 1'b0;
    tick();

    // Single word, start == end == 5.
    rf[5] = 32'hDEADBEEF;
    DREADY = 1'b1;
    clear_q(); d0 = done_cnt;
    start_dump(5'd5, 5'd5);
    chk("one_busy", {31'd0, BUSY}, 32'd1);
    chk("one_halt", {31'd0, HALT_REQ}, 32'd1);
    chk("one_ra", {27'd0, RA}, 32'd5);
    chk("one_dvalid_lat1", {31'd0, DVALID}, 32'd0);
    tick();
    chk("one_dvalid_lat2", {31'd0, DVALID}, 32'd1);
    chk("one_dout", DOUT, 32'hDEADBEEF);
    chk("one_daddr", {27'd0, DADDR}, 32'd5);
    tick();
    chk("one_done", {31'd0, DONE}, 32'd1);
    chk("one_halt_fin", {31'd0, HALT_REQ}, 32'd1);
    chk("one_dvalid_fin", {31'd0, DVALID}, 32'd0);
    tick();
    chk("one_done_off", {31'd0, DONE}, 32'd0);
    chk("one_busy_off", {31'd0, BUSY}, 32'd0);
    chk("one_halt_off", {31'd0, HALT_REQ}, 32'd0);
    chk("one_beats", bq_addr.size(), 32'd1);
    chk("one_done_cnt", done_cnt - d0, 32'd1);

    // Full dump 0..31 with DREADY held high.
    for (int i = 0; i < 32; i++) rf[i] = i * 3;
    clear_q(); d0 = done_cnt;
    start_dump(5'd0, 5'd31);
    wait_idle("full");
    tick();
    chk("full_beats", bq_addr.size(), 32'd32);
    bad = 0;
    for (int i = 0; i < bq_addr.size(); i++)
      if (bq_addr[i] !== 5'(i) || bq_data[i] !== 32'(i * 3)) bad++;
    chk("full_order", bad, 32'd0);
    bad = 0;
    for (int i = 1; i < bq_cyc.size(); i++)
      if (bq_cyc[i] - bq_cyc[i-1] != 2) bad++;
    chk("full_spacing", bad, 32'd0);
    chk("full_done_cnt", done_cnt - d0, 32'd1);

    // Wrap 30..1 with 3 cycles of backpressure per beat.
    DREADY = 1'b0;
    clear_q(); d0 = done_cnt;
    exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0; exp_a[3] = 5'd1;
    start_dump(5'd30, 5'd1);
    for (int b = 0; b < 4; b++) begin
      wait_valid($sformatf("wrap%0d", b));
      hold_d = DOUT; hold_a = DADDR;
      chk($sformatf("wrap_addr%0d", b), {27'd0, DADDR}, {27'd0, exp_a[b]});
      chk($sformatf("wrap_data%0d", b), DOUT, 32'(exp_a[b]) * 3);
      bad = 0;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (!DVALID || DOUT !== hold_d || DADDR !== hold_a) bad++;
      end
      chk($sformatf("wrap_stable%0d", b), bad, 32'd0);
      DREADY = 1'b1;
      tick();
      DREADY = 1'b0;
    end
    wait_idle("wrap");
    tick();
    chk("wrap_beats", bq_addr.size(), 32'd4);
    chk("wrap_done_cnt", done_cnt - d0, 32'd1);

    // Abort while SEND holds address 4.
    DREADY = 1'b1;
    clear_q(); d0 = done_cnt;
    start_dump(5'd0, 5'd31);
    begin
      int n = 0;
      while (!(DVALID && DADDR == 5'd4) && n < 100) begin tick(); n++; end
    end
    chk("abort_at4", {27'd0, DADDR}, 32'd4);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_halt", {31'd0, HALT_REQ}, 32'd0);
    chk("abort_dvalid", {31'd0, DVALID}, 32'd0);
    tick(); tick(); tick();
    chk("abort_beats", bq_addr.size(), 32'd4);
    chk("abort_last", {27'd0, bq_addr[bq_addr.size()-1]}, 32'd3);
    chk("abort_no_done", done_cnt - d0, 32'd0);

    // Write attempts to register 7 held off by HALT_REQ.
    rf[7] = 32'hAAAA5555;
    clear_q();
    start_dump(5'd7, 5'd7);
    rfwa = 5'd7; rfwd = 32'h1234; rfwe = 1'b1;
    tick();
    chk("halt_dout", DOUT, 32'hAAAA5555);
    chk("halt_rf_kept", rf[7], 32'hAAAA5555);
    wait_idle("halt");
    tick();
    rfwe = 1'b0;
    chk("halt_beats", bq_addr.size(), 32'd1);
    chk("halt_write_after", rf[7], 32'h1234);

    // Async reset mid-SEND, no clock edge.
    DREADY = 1'b0;
    start_dump(5'd9, 5'd12);
    wait_valid("rst");
    #2 RST = 1'b1;
    #1;
    chk("arst_dvalid", {31'd0, DVALID}, 32'd0);
    chk("arst_busy", {31'd0, BUSY}, 32'd0);
    chk("arst_halt", {31'd0, HALT_REQ}, 32'd0);
    chk("arst_dout", DOUT, 32'd0);
    chk("arst_daddr", {27'd0, DADDR}, 32'd0);
    chk("arst_ra", {27'd0, RA}, 32'd0);
    tick();
    RST = 1'b0;
    tick();

    // START while busy is ignored.
    clear_q(); d0 = done_cnt;
    start_dump(5'd2, 5'd3);
    wait_valid("ign");
    start_dump(5'd20, 5'd25);
    chk("ign_daddr", {27'd0, DADDR}, 32'd2);
    DREADY = 1'b1;
    wait_idle("ign");
    tick();
    chk("ign_beats", bq_addr.size(), 32'd2);
    if (bq_addr.size() == 2) begin
      chk("ign_addr0", {27'd0, bq_addr[0]}, 32'd2);
      chk("ign_addr1", {27'd0, bq_addr[1]}, 32'd3);
    end
    chk("ign_done_cnt", done_cnt - d0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
